instr_sequencer: RTL
====================

Name: instr_sequencer

Overview:
- Multi-cycle control unit for the 8-bit processor; sequences fetch → decode → execute → writeback.
- Owns PC, instruction register (IR) and zero flag; drives IR into the instruction decoder and consumes its decoded fields.
- Drives register-file read/write addresses and write enable, ALU op select and writeback mux select.
- Fetches from instruction memory over a req/ack handshake.

Parameters:
- RESET_PC, 8'h00, PC value loaded on reset.
- HALT_ON_ILLEGAL, 0, 1 = an illegal opcode enters HALT; 0 = it executes as NOP.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; leaves IDLE/HALT and begins fetching at current pc
- imem_req  out  1  fetch request
- imem_addr  out  8  fetch address (= pc)
- imem_rdata  in  8  fetched instruction, valid when imem_ack=1
- imem_ack  in  1  fetch complete; may assert in the same cycle as imem_req
- ir  out  8  instruction register, to decoder
- opcode  in  4  from decoder
- rdest  in  2  from decoder
- rsrc  in  2  from decoder
- imm  in  4  from decoder
- imm_mode  in  1  from decoder
- alu_zero  in  1  ALU result==0
- rf_raddr_a  out  2  register-file read port A (= rdest)
- rf_raddr_b  out  2  register-file read port B (= rsrc)
- rf_waddr  out  2  register-file write address
- rf_we  out  1  register-file write enable, one-cycle pulse
- alu_op  out  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 PASS_B
- wb_sel  out  1  0 = ALU result, 1 = immediate zero-extended to 8 bits
- pc  out  8  program counter
- zflag  out  1  zero flag
- halted  out  1  high in HALT
- illegal  out  1  sticky; set on an illegal opcode, cleared only by reset

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low. Reset forces state=IDLE, pc=RESET_PC, ir=0, zflag=0, illegal=0. All other outputs are 0 during reset, including imem_req, rf_we and halted.
- Reset mid-operation: imem_req and rf_we drop immediately; the in-flight instruction is discarded.
- States:
  - IDLE: outputs quiet; on start → FETCH.
  - FETCH: imem_req=1, imem_addr=pc. At the edge where imem_ack=1: ir<=imem_rdata, pc<=pc+1 (mod 256), → DECODE. While ack=0, hold req and addr.
  - DECODE: 1 cycle; decoder settles from ir → EXECUTE.
  - EXECUTE: 1 cycle. Drive rf_raddr_a/b and alu_op. Then:
    - ALU ops and CMP: zflag<=alu_zero.
    - Writeback ops → WRITEBACK; NOP/CMP/JR/JZ → FETCH; HALT → HALT.
  - WRITEBACK: 1 cycle. rf_we=1, rf_waddr=rdest. alu_op, read addresses and wb_sel held from EXECUTE → FETCH.
  - HALT: halted=1; on start → FETCH at current pc.
- Opcode map:
  - 0000 NOP.
  - 0001 ADD, 0010 SUB, 0011 AND, 0100 OR: rd <= rd op rs; wb_sel=0.
  - 0101 MOVI (imm_mode=1): rd <= {4'b0, imm}; wb_sel=1; zflag unchanged.
  - 0110 MOV: alu_op=PASS_B, rd <= rs; zflag unchanged.
  - 0111 CMP: SUB, zflag only, no write.
  - 1000 JR: pc <= pc + sext(ir[3:0]), where pc is already incremented; mod 256.
  - 1001 JZ: same as JR if zflag=1, else no change.
  - 1111 HALT.
  - 1010–1110 illegal: illegal<=1; NOP or HALT per HALT_ON_ILLEGAL.
- Latency with same-cycle ack: writeback instruction 4 cycles, others 3.
- start outside IDLE/HALT is ignored. rf_we is never asserted outside WRITEBACK. imem_req is 0 outside FETCH.
- pc wraps: 8'hFF+1 = 8'h00; JR arithmetic is modulo 256.

Test Plan:
- Reset then start, ack same cycle, mem[0]=8'h5B (MOVI, rd=2, imm=B) → rf_we pulse at cycle 4 after start, rf_waddr=2, wb_sel=1, pc=1.
- mem[0..1]=8'h19 (ADD r2,r1), 8'h76 (CMP r1,r2) with alu_zero=1 in CMP's EXECUTE → one rf_we only (ADD), zflag=1 after CMP, pc=2.
- mem[5]=8'h8F (JR -1) → pc returns to 5; imem_addr=5 on every fetch; rf_we never asserted.
- Hold imem_ack=0 for 7 cycles in FETCH → imem_req and imem_addr stable throughout; ir changes only on the ack edge.
- mem[FF]=8'hA0 with HALT_ON_ILLEGAL=0 → illegal=1, pc wraps to 00, execution continues. Then mem[00]=8'hF0 → halted=1; a start pulse resumes fetch at pc=01.
- rst_n low during WRITEBACK → rf_we drops within the same cycle (async); pc=RESET_PC, state=IDLE.

Source files
------------

// File: rtl/instr_sequencer.sv
// Multi-cycle control unit for the 8-bit processor: fetch, decode, execute, writeback.
// Owns PC, IR and the zero flag; steers the register file, ALU and writeback mux.
module instr_sequencer #(
    parameter logic [7:0] RESET_PC        = 8'h00,
    parameter bit         HALT_ON_ILLEGAL = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       imem_req,
    output logic [7:0] imem_addr,
    input  logic [7:0] imem_rdata,
    input  logic       imem_ack,
    output logic [7:0] ir,
    input  logic [3:0] opcode,
    input  logic [1:0] rdest,
    input  logic [1:0] rsrc,
    input  logic [3:0] imm,
    input  logic       imm_mode,
    input  logic       alu_zero,
    output logic [1:0] rf_raddr_a,
    output logic [1:0] rf_raddr_b,
    output logic [1:0] rf_waddr,
    output logic       rf_we,
    output logic [2:0] alu_op,
    output logic       wb_sel,
    output logic [7:0] pc,
    output logic       zflag,
    output logic       halted,
    output logic       illegal
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_WRITEBACK,
        S_HALT
    } state_t;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_MOVI = 4'h5;
    localparam logic [3:0] OP_MOV  = 4'h6;
    localparam logic [3:0] OP_CMP  = 4'h7;
    localparam logic [3:0] OP_JR   = 4'h8;
    localparam logic [3:0] OP_JZ   = 4'h9;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam logic [2:0] ALU_ADD    = 3'b000;
    localparam logic [2:0] ALU_SUB    = 3'b001;
    localparam logic [2:0] ALU_AND    = 3'b010;
    localparam logic [2:0] ALU_OR     = 3'b011;
    localparam logic [2:0] ALU_PASS_B = 3'b100;

    state_t     state_q, state_d;
    logic [7:0] pc_q, pc_d;
    logic [7:0] ir_q, ir_d;
    logic       zflag_q, zflag_d;
    logic       illegal_q, illegal_d;
    logic [2:0] alu_op_dec;
    logic [7:0] pc_jump;

    assign ir        = ir_q;
    assign pc        = pc_q;
    assign imem_addr = pc_q;
    assign zflag     = zflag_q;
    assign illegal   = illegal_q;

    // pc_q has already been incremented past the jump instruction here.
    assign pc_jump = pc_q + {{4{imm[3]}}, imm};

    always_comb begin
        alu_op_dec = ALU_ADD;
        case (opcode)
            OP_SUB, OP_CMP: alu_op_dec = ALU_SUB;
            OP_AND:         alu_op_dec = ALU_AND;
            OP_OR:          alu_op_dec = ALU_OR;
            OP_MOV:         alu_op_dec = ALU_PASS_B;
            default:        alu_op_dec = ALU_ADD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            pc_q      <= RESET_PC;
            ir_q      <= 8'h00;
            zflag_q   <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            zflag_q   <= zflag_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        zflag_d    = zflag_q;
        illegal_d  = illegal_q;
        imem_req   = 1'b0;
        rf_raddr_a = 2'd0;
        rf_raddr_b = 2'd0;
        rf_waddr   = 2'd0;
        rf_we      = 1'b0;
        alu_op     = ALU_ADD;
        wb_sel     = 1'b0;
        halted     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_FETCH;
            end
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    ir_d    = imem_rdata;
                    pc_d    = pc_q + 8'd1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                state_d = S_EXECUTE;
            end
            S_EXECUTE: begin
                rf_raddr_a = rdest;
                rf_raddr_b = rsrc;
                alu_op     = alu_op_dec;
                wb_sel     = imm_mode;
                case (opcode)
                    OP_NOP: state_d = S_FETCH;
                    OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                        zflag_d = alu_zero;
                        state_d = S_WRITEBACK;
                    end
                    OP_MOVI, OP_MOV: state_d = S_WRITEBACK;
                    OP_CMP: begin
                        zflag_d = alu_zero;
                        state_d = S_FETCH;
                    end
                    OP_JR: begin
                        pc_d    = pc_jump;
                        state_d = S_FETCH;
                    end
                    OP_JZ: begin
                        if (zflag_q) pc_d = pc_jump;
                        state_d = S_FETCH;
                    end
                    OP_HALT: state_d = S_HALT;
                    default: begin
                        illegal_d = 1'b1;
                        state_d   = HALT_ON_ILLEGAL ? S_HALT : S_FETCH;
                    end
                endcase
            end
            S_WRITEBACK: begin
                // Datapath controls stay as in EXECUTE so the write sees a stable result.
                rf_raddr_a = rdest;
                rf_raddr_b = rsrc;
                alu_op     = alu_op_dec;
                wb_sel     = imm_mode;
                rf_waddr   = rdest;
                rf_we      = 1'b1;
                state_d    = S_FETCH;
            end
            S_HALT: begin
                halted = 1'b1;
                if (start) state_d = S_FETCH;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule
